// File: rtl/trit_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// trit_serial_adder_pkg
//
// Purpose: shared definitions for the serial ternary adder slice.
//   - Two-bit trit encoding constants (ZERO, ONE, TWO, INV)
//   - Default word length in trits
//   - FSM state encoding used by the top level
//   - Small helper for recognising the invalid trit code
//
// No ports (package).
// ---------------------------------------------------------------------------
package trit_serial_adder_pkg;

    // Trit encoding: 00=0, 01=1, 10=2, 11=invalid.
    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] ONE  = 2'b01;
    localparam logic [1:0] TWO  = 2'b10;
    localparam logic [1:0] INV  = 2'b11;

    // Default number of trits per word.
    localparam int DEFAULT_TRITS = 4;

    // Word-level controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when a trit carries the reserved code.
    function automatic logic trit_is_invalid(input logic [1:0] t);
        return (t == INV);
    endfunction

endpackage : trit_serial_adder_pkg

// File: rtl/trit_serial_adder_full_adder.sv
// ---------------------------------------------------------------------------
// trit_full_adder
//
// Purpose: purely combinational single-trit ternary full adder.
//   t = a + b + cin (0..5); digit = t mod 3; cout = (t >= 3).
//   An operand carrying the reserved code is treated as zero and reported on
//   'invalid' so the word-level logic can latch an error flag.
//
// Ports:
//   a       [1:0] in   operand A trit
//   b       [1:0] in   operand B trit
//   cin           in   incoming carry (0 or 1)
//   digit   [1:0] out  result trit, always 0, 1 or 2
//   cout          out  outgoing carry
//   invalid       out  high when a or b carried the reserved code
// ---------------------------------------------------------------------------
module trit_full_adder
    import trit_serial_adder_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] digit,
    output logic       cout,
    output logic       invalid
);

    logic       a_bad;
    logic       b_bad;
    logic [1:0] a_val;
    logic [1:0] b_val;
    logic [2:0] total;
    logic [2:0] reduced;

    // Sanitise the operands: the reserved code contributes nothing to the sum,
    // which also guarantees the digit below can never land on code 11.
    always_comb begin
        a_bad = trit_is_invalid(a);
        b_bad = trit_is_invalid(b);
        a_val = a_bad ? ZERO : a;
        b_val = b_bad ? ZERO : b;
    end

    // Three-bit sum is enough for the 0..5 range. A single conditional
    // subtract of 3 performs the mod-3 reduction because t never reaches 6.
    always_comb begin
        total   = {1'b0, a_val} + {1'b0, b_val} + {2'b00, cin};
        cout    = (total >= 3'd3);
        reduced = cout ? (total - 3'd3) : total;
        digit   = reduced[1:0];
        invalid = a_bad | b_bad;
    end

endmodule : trit_full_adder

// File: rtl/trit_serial_adder.sv
// ---------------------------------------------------------------------------
// trit_serial_adder
//
// Purpose: adds two TRITS-trit ternary words delivered serially, LSB first,
//   one trit pair per accepted beat. The result word is held with a
//   valid/ready handshake until the consumer takes it.
//
// Parameters:
//   TRITS           trits per word, legal range 2..16
//
// Ports:
//   clk                  in   single clock, rising edge
//   rst                  in   synchronous active-high reset
//   in_valid             in   a trit-pair beat is present
//   in_ready             out  the block accepts a beat (IDLE and RUN)
//   a_trit     [1:0]     in   operand A trit
//   b_trit     [1:0]     in   operand B trit
//   out_valid            out  a completed result word is held (DONE)
//   out_ready            in   consumer accepts the result
//   sum        [2T-1:0]  out  result word, trit i at bits [2i+1:2i]
//   carry_out            out  final carry of the word (overflow)
//   err                  out  some beat of the word carried the invalid code
// ---------------------------------------------------------------------------
module trit_serial_adder
    import trit_serial_adder_pkg::*;
#(
    parameter int TRITS = DEFAULT_TRITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           a_trit,
    input  logic [1:0]           b_trit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*TRITS-1:0]   sum,
    output logic                 carry_out,
    output logic                 err
);

    // The counter must be able to hold TRITS itself because it keeps counting
    // through the final beat and sits there while the word is held in DONE.
    localparam int              CNT_W     = $clog2(TRITS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TRITS - 1);

    state_t             state_q;
    state_t             state_d;

    logic [CNT_W-1:0]   beat_cnt;
    logic               carry_q;
    logic               err_q;
    logic [2*TRITS-1:0] sum_q;

    logic               accept;
    logic               consume;
    logic               last_beat;

    logic [1:0]         fa_digit;
    logic               fa_cout;
    logic               fa_invalid;

    // One trit column of the addition. The running carry register is cleared
    // between words, so the first beat of every word starts with cin = 0.
    trit_full_adder u_fa (
        .a       (a_trit),
        .b       (b_trit),
        .cin     (carry_q),
        .digit   (fa_digit),
        .cout    (fa_cout),
        .invalid (fa_invalid)
    );

    // State register. Reset wins over everything, including a pending
    // handshake, so a held or partial result is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode. in_ready is low only in DONE, which is
    // what makes in_valid irrelevant while a result is waiting to be taken.
    // Consumption returns to IDLE, so in_ready comes back the following cycle
    // rather than in the same cycle as the output handshake.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        last_beat = (beat_cnt == LAST_BEAT);

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                consume   = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: each accepted beat writes its digit into the trit slot chosen
    // by the beat counter, advances the carry, and accumulates the error flag.
    // Nothing changes in DONE until the word is consumed, which keeps sum,
    // carry_out and err stable under backpressure. Consumption clears the
    // word so the next one starts from a clean carry and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            sum_q    <= '0;
        end else if (consume) begin
            beat_cnt <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            sum_q    <= '0;
        end else if (accept) begin
            sum_q[2*beat_cnt +: 2] <= fa_digit;
            carry_q                <= fa_cout;
            err_q                  <= err_q | fa_invalid;
            beat_cnt               <= beat_cnt + 1'b1;
        end
    end

    // After the last beat the running carry is the word's overflow carry.
    always_comb begin
        sum       = sum_q;
        carry_out = carry_q;
        err       = err_q;
    end

endmodule : trit_serial_adder

// File: tb/tb_trit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_trit_serial_adder
//
// Purpose: self-checking bench for trit_serial_adder with TRITS = 4.
//   A table of directed word-level vectors with hand-computed results is
//   streamed through the adder, followed by hand-written sequences for
//   backpressure, reset mid-word, reset while holding a result, and gaps.
// ---------------------------------------------------------------------------
module tb_trit_serial_adder;

    localparam int TRITS = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       a_trit;
    logic [1:0]       b_trit;
    logic             out_valid;
    logic             out_ready;
    logic [2*TRITS-1:0] sum;
    logic             carry_out;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] a_word;
        logic [7:0] b_word;
        logic [7:0] exp_sum;
        logic       exp_carry;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    trit_serial_adder #(.TRITS(TRITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_trit    (a_trit),
        .b_trit    (b_trit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .err       (err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the handshake.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive nbeats trit pairs LSB first. With gaps enabled, a random number of
    // idle cycles with garbage operands precedes each beat; the block must
    // ignore them. Returns one step after the edge that took the last beat.
    task automatic applyStimulus(input logic [7:0] aw, input logic [7:0] bw,
                                 input int nbeats, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                int n;
                n        = int'($urandom_range(0, 3));
                in_valid = 1'b0;
                a_trit   = 2'b11;
                b_trit   = 2'b10;
                for (int g = 0; g < n; g++) tick();
            end
            check("in_ready_during_word", in_ready, 1);
            in_valid = 1'b1;
            a_trit   = aw[2*k +: 2];
            b_trit   = bw[2*k +: 2];
            tick();
        end
        in_valid = 1'b0;
        a_trit   = 2'b00;
        b_trit   = 2'b00;
    endtask

    // Called right after the last beat: out_valid must already be high
    // (one-cycle latency). Then compare the word, perform the handshake and
    // confirm in_ready returns the following cycle.
    task automatic checkOutput(input string name, input logic [7:0] exp_sum,
                               input logic exp_carry, input logic exp_err);
        check({name, "_latency_out_valid"}, out_valid, 1);
        check({name, "_sum"},   sum,       exp_sum);
        check({name, "_carry"}, carry_out, exp_carry);
        check({name, "_err"},   err,       exp_err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_out_valid_cleared"}, out_valid, 0);
        check({name, "_in_ready_back"},     in_ready,  1);
    endtask

    task automatic checkResetState(input string name);
        check({name, "_in_ready"},  in_ready,  1);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_sum"},       sum,       0);
        check({name, "_carry"},     carry_out, 0);
        check({name, "_err"},       err,       0);
    endtask

    initial begin
        // Words written as packed trits, trit 0 in bits [1:0].
        vecs[0] = '{"basic",      8'h55, 8'h01, 8'h56, 1'b0, 1'b0};
        vecs[1] = '{"overflow",   8'hAA, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"inv_a",      8'h5D, 8'h00, 8'h51, 1'b0, 1'b1};
        vecs[3] = '{"err_clears", 8'h55, 8'h01, 8'h56, 1'b0, 1'b0};
        vecs[4] = '{"mixed",      8'h66, 8'h91, 8'h48, 1'b1, 1'b0};
        vecs[5] = '{"zero",       8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{"inv_b",      8'h00, 8'hEA, 8'h2A, 1'b0, 1'b1};
        vecs[7] = '{"max",        8'hAA, 8'hAA, 8'hA9, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_trit    = 2'b00;
        b_trit    = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        checkResetState("reset");

        // Table-driven words, back to back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a_word, vecs[i].b_word, TRITS, 1'b0);
            checkOutput(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_carry, vecs[i].exp_err);
        end

        // Backpressure: hold the result for three cycles while offering a
        // beat that must be ignored, then drain and run a clean word.
        applyStimulus(8'h55, 8'h01, TRITS, 1'b0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a_trit   = 2'b11;
            b_trit   = 2'b10;
            check("bp_in_ready",  in_ready,  0);
            check("bp_out_valid", out_valid, 1);
            check("bp_sum",       sum,       8'h56);
            check("bp_carry",     carry_out, 0);
            check("bp_err",       err,       0);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("bp_drain", 8'h56, 1'b0, 1'b0);
        applyStimulus(8'h66, 8'h91, TRITS, 1'b0);
        checkOutput("bp_after", 8'h48, 1'b1, 1'b0);

        // Reset after two overflow beats: the pending carry must not leak.
        applyStimulus(8'hAA, 8'h01, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState("rst_mid");
        applyStimulus(8'h55, 8'h01, TRITS, 1'b0);
        checkOutput("rst_mid_next", 8'h56, 1'b0, 1'b0);

        // Reset while a result is held discards it.
        applyStimulus(8'h5D, 8'hAA, TRITS, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState("rst_done");

        // Gaps between beats give the same result as the gap-free run.
        applyStimulus(8'h66, 8'h91, TRITS, 1'b1);
        checkOutput("gaps_mixed", 8'h48, 1'b1, 1'b0);
        applyStimulus(8'hAA, 8'hAA, TRITS, 1'b1);
        checkOutput("gaps_max", 8'hA9, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trit_serial_adder
